// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzc_nb.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module lzc_nb
  import div_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Scan upward so the highest set bit is the one that finally sets the count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_nb.sv
// Iterative restoring divider with leading-zero skip, signed/unsigned mode,
// valid/ready handshakes and RISC-V style divide-by-zero / overflow results.
module div_nb
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam int             CW      = count_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [CW-1:0]    count;
  logic             neg_quot;
  logic             neg_rem;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag_c;
  logic [CW-1:0]    lead_zeros;
  logic [CW-1:0]    n_bits;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;

  // Operand magnitudes and the significant-bit count used while in PREP.
  always_comb begin
    sign_a        = signed_reg & dividend_reg[WIDTH-1];
    sign_b        = signed_reg & divisor_reg[WIDTH-1];
    dividend_mag  = sign_a ? -dividend_reg : dividend_reg;
    divisor_mag_c = sign_b ? -divisor_reg : divisor_reg;
    n_bits        = CW'(WIDTH) - lead_zeros;
  end

  lzc_nb #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .value(dividend_mag),
    .count(lead_zeros)
  );

  // Restoring trial subtraction; a non-negative result is always below the
  // divisor, so both the sign bit and bit WIDTH are clear when it succeeds.
  always_comb begin
    partial  = {rem_reg, shift_reg[WIDTH-1]};
    trial    = {1'b0, partial} - {2'b00, divisor_mag};
    trial_ok = ~trial[WIDTH+1] & ~trial[WIDTH];
    rem_next = trial_ok ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  end

  // Control FSM together with the datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      in_ready_o   <= 1'b1;
      out_valid_o  <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
      div_zero_o   <= 1'b0;
      overflow_o   <= 1'b0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      signed_reg   <= 1'b0;
      divisor_mag  <= '0;
      shift_reg    <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      count        <= '0;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            dividend_reg <= dividend_i;
            divisor_reg  <= divisor_i;
            signed_reg   <= signed_i;
            div_zero_o   <= 1'b0;
            overflow_o   <= 1'b0;
            in_ready_o   <= 1'b0;
            state        <= PREP;
          end
        end
        PREP: begin
          divisor_mag <= divisor_mag_c;
          neg_quot    <= sign_a ^ sign_b;
          neg_rem     <= sign_a;
          shift_reg   <= dividend_mag << lead_zeros;
          rem_reg     <= '0;
          quot_reg    <= '0;
          count       <= n_bits;
          if (divisor_reg == '0) begin
            quotient_o  <= '1;
            remainder_o <= dividend_reg;
            div_zero_o  <= 1'b1;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else if (signed_reg && dividend_reg == MIN_VAL && divisor_reg == '1) begin
            quotient_o  <= MIN_VAL;
            remainder_o <= '0;
            overflow_o  <= 1'b1;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else if (n_bits == '0) begin
            state <= FIX;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          shift_reg <= shift_reg << 1;
          rem_reg   <= rem_next;
          quot_reg  <= {quot_reg[WIDTH-2:0], trial_ok};
          count     <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient_o  <= neg_quot ? -quot_reg : quot_reg;
          remainder_o <= neg_rem ? -rem_reg : rem_reg;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
